// File: rtl/frame_cmd_dispatcher.sv
// HPS command FIFO replayed one word/clk onto the display command bus; 2-clk write-to-bus latency.
// Swap words (info==F) wait for vblank, once per frame; waitrequest is high exactly while the FIFO is full.
module frame_cmd_dispatcher #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [9:0]  VACTIVE    = 10'd480,
  parameter logic [31:0] IDLE_WORD  = 32'h0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            chipselect,
  input  logic                            write,
  input  logic [31:0]                     writedata,
  output logic                            waitrequest,
  input  logic [9:0]                      vcount,
  output logic [31:0]                     cmd_out,
  output logic                            cur_buffer,
  output logic                            swap_pending,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {RUN, WAIT_VBL} state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [LW-1:0] level;
  logic          swap_done;

  logic          full;
  logic          empty;
  logic          vblank;
  logic [31:0]   head;
  logic          head_swap;
  logic          wr_req;
  logic          pop;
  logic          push;

  assign full        = (level == LW'(FIFO_DEPTH));
  assign empty       = (level == '0);
  assign vblank      = (vcount >= VACTIVE);
  assign head        = mem[rd_ptr];
  assign head_swap   = (head[20:17] == 4'hF);
  assign wr_req      = chipselect & write;
  assign waitrequest = full;
  assign fifo_level  = level;

  // WAIT_VBL is only ever entered with a swap at the head, so no empty check is needed there.
  always_comb begin
    pop = 1'b0;
    if (state == RUN)
      pop = !empty && !head_swap;
    else
      pop = vblank && !swap_done;
  end

  // A pop in the same cycle frees the slot, so a write at full is still taken then.
  assign push = wr_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      swap_done    <= 1'b0;
      cmd_out      <= IDLE_WORD;
      cur_buffer   <= 1'b0;
      swap_pending <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      cmd_out <= pop ? head : IDLE_WORD;

      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (wr_req && !push)
        overflow <= 1'b1;

      if (!vblank)
        swap_done <= 1'b0;

      case (state)
        RUN: begin
          if (!empty && head_swap) begin
            state        <= WAIT_VBL;
            swap_pending <= 1'b1;
          end
        end
        WAIT_VBL: begin
          if (vblank && !swap_done) begin
            state        <= RUN;
            swap_pending <= 1'b0;
            cur_buffer   <= head[13];
            swap_done    <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_cmd_dispatcher.sv
// Bench for frame_cmd_dispatcher: directed scenarios plus random traffic against a queue-based model
// of the command stream (strict order, swaps held to one per vblank).
module tb_frame_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        cur_buffer;
  logic        swap_pending;
  logic [4:0]  fifo_level;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_cmd_dispatcher #(
    .FIFO_DEPTH (16),
    .VACTIVE    (10'd480),
    .IDLE_WORD  (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .writedata    (writedata),
    .waitrequest  (waitrequest),
    .vcount       (vcount),
    .cmd_out      (cmd_out),
    .cur_buffer   (cur_buffer),
    .swap_pending (swap_pending),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  // Reference: queued words, visible buffer, "swap already used this vblank", swap seen at head.
  logic [31:0] q[$];
  bit          m_cur;
  bit          m_done;
  bit          m_armed;
  bit          m_ovf;
  logic [31:0] e_cmd;

  logic [40:0] dut_vec;
  assign dut_vec = {cmd_out, fifo_level, waitrequest, swap_pending, cur_buffer, overflow};

  function automatic bit is_swap(logic [31:0] w);
    return w[20:17] == 4'hF;
  endfunction

  function automatic logic [40:0] exp_vec();
    return {e_cmd, 5'(q.size()), (q.size() == 16), m_armed, m_cur, m_ovf};
  endfunction

  task automatic model_clear();
    q.delete();
    m_cur = 0; m_done = 0; m_armed = 0; m_ovf = 0; e_cmd = 32'h0;
  endtask

  // Advance the model with the inputs as they stand, then one clock on the DUT.
  task automatic tick();
    bit          vbl;
    bit          issue;
    bit          armed_n;
    bit          done_n;
    logic [31:0] w;
    vbl = (vcount >= 10'd480);
    issue = 0; w = 32'h0; armed_n = m_armed; done_n = m_done;
    if (q.size() > 0) begin
      if (!is_swap(q[0])) issue = 1;
      else if (!m_armed) armed_n = 1;
      else if (vbl && !m_done) begin
        issue = 1; m_cur = q[0][13]; done_n = 1; armed_n = 0;
      end
    end
    if (!vbl) done_n = 0;
    if (issue) w = q.pop_front();
    if (chipselect && write) begin
      if (q.size() < 16) q.push_back(writedata);
      else m_ovf = 1;
    end
    m_armed = armed_n; m_done = done_n;
    e_cmd = issue ? w : 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    chipselect = 0; write = 0; writedata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 0; vcount = 10'd0; idle_bus(); model_clear();
    repeat (2) @(posedge clk); #1;
    checks++;
    if (dut_vec !== 41'h0) begin failures++; $display("FAIL reset_init got=%h want=%h", dut_vec, 41'h0); end
    reset = 1; vcount = 10'd100;
    for (int i = 0; i < 5; i++) begin
      chipselect = 1; write = 1; writedata = (i == 0) ? 32'h001E2000 : 32'h08200A10 + i;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL reset_fill got=%h want=%h", dut_vec, exp_vec()); end
    end
    idle_bus(); tick();
    checks++;
    if (fifo_level !== 5'd5) begin failures++; $display("FAIL reset_level5 got=%0d want=5", fifo_level); end
    #2 reset = 0; #1;
    model_clear();
    checks++;
    if (dut_vec !== 41'h0) begin failures++; $display("FAIL reset_mid got=%h want=%h", dut_vec, 41'h0); end
    @(posedge clk); #1; reset = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (cmd_out !== 32'h0 || fifo_level !== 5'd0 || swap_pending !== 1'b0) begin
        failures++; $display("FAIL reset_after cmd=%h lvl=%0d pend=%b want 0/0/0", cmd_out, fifo_level, swap_pending);
      end
    end
  endtask

  task automatic test_burst();
    vcount = 10'd100;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin chipselect = 1; write = 1; writedata = 32'h08200A05 + i; end
      else idle_bus();
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL burst cyc%0d got=%h want=%h", i, dut_vec, exp_vec()); end
      if (i == 1) begin
        checks++;
        if (cmd_out !== 32'h08200A05) begin failures++; $display("FAIL burst_first got=%h want=08200a05", cmd_out); end
      end
    end
  endtask

  task automatic test_swap_hold();
    vcount = 10'd100;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin chipselect = 1; write = 1; writedata = 32'h001E2000; end
      else if (i == 1) writedata = 32'h08200A20;
      else idle_bus();
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL swap_hold cyc%0d got=%h want=%h", i, dut_vec, exp_vec()); end
    end
    checks++;
    if (swap_pending !== 1'b1 || cmd_out !== 32'h0) begin
      failures++; $display("FAIL swap_held pend=%b cmd=%h want 1/0", swap_pending, cmd_out);
    end
    vcount = 10'd480; tick();
    checks++;
    if (cmd_out !== 32'h001E2000 || cur_buffer !== 1'b1) begin
      failures++; $display("FAIL swap_issue cmd=%h buf=%b want 001e2000/1", cmd_out, cur_buffer);
    end
    tick();
    checks++;
    if (cmd_out !== 32'h08200A20) begin failures++; $display("FAIL swap_follow got=%h want=08200a20", cmd_out); end
  endtask

  task automatic test_double_swap();
    vcount = 10'd100; tick();
    vcount = 10'd481;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin chipselect = 1; write = 1; writedata = 32'h001E0000; end
      else if (i == 1) writedata = 32'h001E2000;
      else idle_bus();
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL dswap cyc%0d got=%h want=%h", i, dut_vec, exp_vec()); end
    end
    checks++;
    if (swap_pending !== 1'b1 || cur_buffer !== 1'b0 || fifo_level !== 5'd1) begin
      failures++; $display("FAIL dswap_held pend=%b buf=%b lvl=%0d want 1/0/1", swap_pending, cur_buffer, fifo_level);
    end
    vcount = 10'd100;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (swap_pending !== 1'b1 || cmd_out !== 32'h0) begin
      failures++; $display("FAIL dswap_active pend=%b cmd=%h want 1/0", swap_pending, cmd_out);
    end
    vcount = 10'd480; tick();
    checks++;
    if (cmd_out !== 32'h001E2000 || cur_buffer !== 1'b1) begin
      failures++; $display("FAIL dswap_second cmd=%h buf=%b want 001e2000/1", cmd_out, cur_buffer);
    end
  endtask

  task automatic test_full_overflow();
    vcount = 10'd0;
    for (int i = 0; i < 16; i++) begin
      chipselect = 1; write = 1; writedata = (i == 0) ? 32'h001E0000 : 32'h08200B00 + i;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL fill cyc%0d got=%h want=%h", i, dut_vec, exp_vec()); end
    end
    checks++;
    if (fifo_level !== 5'd16 || waitrequest !== 1'b1) begin
      failures++; $display("FAIL full lvl=%0d wait=%b want 16/1", fifo_level, waitrequest);
    end
    write = 0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (overflow !== 1'b0 || fifo_level !== 5'd16) begin
      failures++; $display("FAIL held_write ovf=%b lvl=%0d want 0/16", overflow, fifo_level);
    end
    write = 1; writedata = 32'hDEADBEEF; tick();
    checks++;
    if (overflow !== 1'b1 || fifo_level !== 5'd16) begin
      failures++; $display("FAIL overflow ovf=%b lvl=%0d want 1/16", overflow, fifo_level);
    end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    vcount = 10'd480;
    chipselect = 1; write = 1; writedata = 32'h08200C00;
    tick();
    checks++;
    if (fifo_level !== 5'd16 || cmd_out !== 32'h001E0000 || cur_buffer !== 1'b0) begin
      failures++; $display("FAIL simul lvl=%0d cmd=%h buf=%b want 16/001e0000/0", fifo_level, cmd_out, cur_buffer);
    end
    idle_bus();
    for (int i = 0; i < 18; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL drain cyc%0d got=%h want=%h", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_random();
    logic [9:0]  vtab [6];
    logic [31:0] w;
    int          n;
    vtab[0] = 10'd0; vtab[1] = 10'd100; vtab[2] = 10'd479;
    vtab[3] = 10'd480; vtab[4] = 10'd481; vtab[5] = 10'd524;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) vcount = vtab[$urandom_range(5)];
      w = $urandom();
      if ($urandom_range(3) == 0) w[20:17] = 4'hF;
      else if (w[20:17] == 4'hF) w[20:17] = 4'h1;
      chipselect = ($urandom_range(3) != 0);
      write = ($urandom_range(2) != 0);
      writedata = w;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL random cyc%0d got=%h want=%h", i, dut_vec, exp_vec()); end
    end
    idle_bus();
    n = 0;
    while (q.size() > 0 && n < 400) begin
      vcount = ((n / 4) % 2 == 0) ? 10'd100 : 10'd480;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL rdrain cyc%0d got=%h want=%h", n, dut_vec, exp_vec()); end
      n++;
    end
    checks++;
    if (q.size() != 0 || fifo_level !== 5'd0) begin
      failures++; $display("FAIL rdrain_empty lvl=%0d model=%0d want 0", fifo_level, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_swap_hold();
    test_double_swap();
    test_full_overflow();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
